// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32x8 memory port between two requesters,
// with an optional per-port lock bounded by a timeout.
module mem_arbiter #(
  parameter int unsigned AW              = 5,
  parameter int unsigned DW              = 8,
  parameter int unsigned MAX_LOCK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_q, prio_d;   // port favoured on the next tie
  logic          rd_port_q;        // which port the in-flight read belongs to
  logic          lock_held;
  logic          expired;

  // Next-state, lock bookkeeping and combinational grant
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    lock_held = (state_q == LOCKED) && (owner_q ? lock1 : lock0);
    expired   = lock_held && (cnt_q >= LOCK_MAX);

    if (lock_held) begin
      state_d = LOCKED;
      cnt_d   = expired ? cnt_q : cnt_q + CW'(1);
      if (expired && (owner_q ? req0 : req1)) begin
        // timeout: the waiting port gets one beat, then the lock resumes
        gnt0  = owner_q;
        gnt1  = ~owner_q;
        cnt_d = '0;
      end else begin
        gnt0 = ~owner_q & req0;
        gnt1 = owner_q & req1;
      end
    end else begin
      if (req0 && (!req1 || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end

      if ((gnt0 && lock0) || (gnt1 && lock1)) begin
        state_d = LOCKED;
        owner_d = gnt1;
        cnt_d   = '0;
      end else if (gnt0 || gnt1) begin
        state_d = ACCESS;
      end else begin
        state_d = IDLE;
      end
    end

    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) prio_d = 1'b1;
    if (gnt1) prio_d = 1'b0;
  end

  // State register and registered memory / response datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      rd_port_q <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;

      mem_rd <= (gnt0 & ~we0) | (gnt1 & ~we1);
      mem_wr <= (gnt0 & we0) | (gnt1 & we1);
      if (gnt0 || gnt1) begin
        mem_addr  <= gnt1 ? addr1 : addr0;
        mem_wdata <= gnt1 ? wdata1 : wdata0;
        rd_port_q <= gnt1;
      end

      rvalid0 <= mem_rd & ~rd_port_q;
      rvalid1 <= mem_rd & rd_port_q;
      if (mem_rd && !rd_port_q) rdata0 <= mem_rdata;
      if (mem_rd && rd_port_q)  rdata1 <= mem_rdata;
    end
  end

endmodule
